// File: rtl/mmio_pkg.sv
// Shared constants, register map and helpers for the data-side memory subsystem.
package mmio_pkg;

    localparam logic [3:0]  RAM_REGION = 4'h0;
    localparam logic [19:0] MMIO_PAGE  = 20'h10000;

    localparam logic [11:0] OFF_TXDATA      = 12'h000;
    localparam logic [11:0] OFF_STATUS      = 12'h004;
    localparam logic [11:0] OFF_MTIME_LO    = 12'h008;
    localparam logic [11:0] OFF_MTIME_HI    = 12'h00C;
    localparam logic [11:0] OFF_MTIMECMP_LO = 12'h010;
    localparam logic [11:0] OFF_MTIMECMP_HI = 12'h014;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mmio_data_mem_if.sv
// M-stage data port: byte address, lane-aligned store data, byte mask and load data.
interface mmio_data_mem_if;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  wmask;
    logic        wen;
    logic [31:0] read_data;

    modport master (output address, output write_data, output wmask, output wen,
                    input  read_data);
    modport slave  (input  address, input  write_data, input  wmask, input  wen,
                    output read_data);
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular TX FIFO feeding an 8N1 serial transmitter with a sticky overflow flag.
module uart_tx_fifo
    import mmio_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 868,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1,
    localparam int BW = $clog2(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_ovf_clr,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count,
    output logic          o_busy,
    output logic          o_overflow,
    output logic          o_tx
);

    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    uart_state_t   r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push_ok;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == {CW{1'b0}});
    assign w_pop     = (r_state == IDLE) && !w_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push_ok = i_push && (!w_full || w_pop);

    // Storage array; contents are meaningless once pointers are reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && !w_push_ok) r_ovf <= 1'b1;
            else if (i_ovf_clr)       r_ovf <= 1'b0;
        end
    end

    // Transmit state machine; the line output is registered and idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_baud  <= {BW{1'b0}};
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_baud  <= BAUD_RELOAD;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (r_baud == {BW{1'b0}}) begin
                        r_baud  <= BAUD_RELOAD;
                        r_bit   <= 3'd0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                DATA: begin
                    if (r_baud == {BW{1'b0}}) begin
                        r_baud <= BAUD_RELOAD;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[1];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                STOP: begin
                    if (r_baud == {BW{1'b0}}) begin
                        r_state <= IDLE;
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_busy     = (r_state != IDLE);
    assign o_overflow = r_ovf;
    assign o_tx       = r_tx;

endmodule

// File: rtl/mmio_data_mem.sv
// Data-side memory: word RAM plus an MMIO page with a 64-bit machine timer and a UART TX.
module mmio_data_mem
    import mmio_pkg::*;
#(
    parameter int RAM_WORDS       = 1024,
    parameter int UART_FIFO_DEPTH = 8,
    parameter int CLKS_PER_BIT    = 868
) (
    input  logic            clk,
    input  logic            reset,
    mmio_data_mem_if.slave  bus,
    output logic            uart_tx,
    output logic            timer_irq
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(UART_FIFO_DEPTH) + 1;

    logic [31:0]       r_ram [RAM_WORDS];
    logic [63:0]       r_mtime;
    logic [63:0]       r_mtimecmp;
    logic              r_timer_irq;

    logic              w_is_ram;
    logic              w_is_mmio;
    logic [11:0]       w_off;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_mmio_wr;
    logic              w_push;
    logic              w_ovf_clr;
    logic [63:0]       w_mtime_inc;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic              w_busy;
    logic              w_overflow;
    logic [31:0]       w_status;
    logic              w_unused;

    assign w_is_ram    = (bus.address[31:28] == RAM_REGION);
    assign w_is_mmio   = (bus.address[31:12] == MMIO_PAGE);
    assign w_off       = bus.address[11:0];
    assign w_ram_idx   = bus.address[RAM_AW+1:2];
    assign w_mmio_wr   = bus.wen && w_is_mmio;
    assign w_push      = w_mmio_wr && (w_off == OFF_TXDATA) && bus.wmask[0];
    assign w_ovf_clr   = w_mmio_wr && (w_off == OFF_STATUS) && bus.wmask[0]
                         && bus.write_data[ST_OVF];
    assign w_mtime_inc = r_mtime + 64'd1;
    assign w_unused    = &{1'b0, bus.address[1:0]};

    uart_tx_fifo #(
        .DEPTH        (UART_FIFO_DEPTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_data     (bus.write_data[7:0]),
        .i_ovf_clr  (w_ovf_clr),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_busy     (w_busy),
        .o_overflow (w_overflow),
        .o_tx       (uart_tx)
    );

    // Byte-lane RAM stores; the array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (bus.wen && w_is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wmask[i]) begin
                    r_ram[w_ram_idx][8*i +: 8] <= bus.write_data[8*i +: 8];
                end
            end
        end
    end

    // Free-running timer; a store to a half replaces its incremented value, carry still reaches HI.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mtime     <= 64'd0;
            r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_timer_irq <= 1'b0;
        end else begin
            r_mtime[31:0]  <= (w_mmio_wr && (w_off == OFF_MTIME_LO))
                              ? merge_bytes(w_mtime_inc[31:0], bus.write_data, bus.wmask)
                              : w_mtime_inc[31:0];
            r_mtime[63:32] <= (w_mmio_wr && (w_off == OFF_MTIME_HI))
                              ? merge_bytes(w_mtime_inc[63:32], bus.write_data, bus.wmask)
                              : w_mtime_inc[63:32];
            if (w_mmio_wr && (w_off == OFF_MTIMECMP_LO)) begin
                r_mtimecmp[31:0] <= merge_bytes(r_mtimecmp[31:0], bus.write_data, bus.wmask);
            end
            if (w_mmio_wr && (w_off == OFF_MTIMECMP_HI)) begin
                r_mtimecmp[63:32] <= merge_bytes(r_mtimecmp[63:32], bus.write_data, bus.wmask);
            end
            r_timer_irq <= (r_mtime >= r_mtimecmp);
        end
    end

    assign timer_irq = r_timer_irq;

    // STATUS word assembly.
    always_comb begin
        w_status                      = 32'd0;
        w_status[ST_FULL]             = w_full;
        w_status[ST_EMPTY]            = w_empty;
        w_status[ST_BUSY]             = w_busy;
        w_status[ST_OVF]              = w_overflow;
        w_status[ST_CNT_LSB +: 4]     = 4'(w_count);
    end

    // Load data mux; unmapped addresses and unused MMIO offsets read as zero.
    always_comb begin
        bus.read_data = 32'd0;
        if (w_is_ram) begin
            bus.read_data = r_ram[w_ram_idx];
        end else if (w_is_mmio) begin
            case (w_off)
                OFF_STATUS:      bus.read_data = w_status;
                OFF_MTIME_LO:    bus.read_data = r_mtime[31:0];
                OFF_MTIME_HI:    bus.read_data = r_mtime[63:32];
                OFF_MTIMECMP_LO: bus.read_data = r_mtimecmp[31:0];
                OFF_MTIMECMP_HI: bus.read_data = r_mtimecmp[63:32];
                default:         bus.read_data = 32'd0;
            endcase
        end else begin
            bus.read_data = 32'd0;
        end
    end

endmodule

// File: tb/tb_mmio_data_mem.sv
// Scoreboard bench: stimulus queues expectations, negedge monitor and a UART receiver compare.
module tb_mmio_data_mem;
    import mmio_pkg::*;

    localparam int          CPB       = 4;
    localparam logic [31:0] MMIO_BASE = 32'h1000_0000;
    localparam logic [31:0] A_TX  = MMIO_BASE | 32'(OFF_TXDATA);
    localparam logic [31:0] A_ST  = MMIO_BASE | 32'(OFF_STATUS);
    localparam logic [31:0] A_MLO = MMIO_BASE | 32'(OFF_MTIME_LO);
    localparam logic [31:0] A_MHI = MMIO_BASE | 32'(OFF_MTIME_HI);
    localparam logic [31:0] A_CLO = MMIO_BASE | 32'(OFF_MTIMECMP_LO);
    localparam logic [31:0] A_CHI = MMIO_BASE | 32'(OFF_MTIMECMP_HI);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic uart_tx;
    logic timer_irq;

    mmio_data_mem_if bus();

    mmio_data_mem #(
        .RAM_WORDS       (1024),
        .UART_FIFO_DEPTH (8),
        .CLKS_PER_BIT    (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .uart_tx   (uart_tx),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] rx_q[$];
    int         chk_n     = 0;
    int         n_vec     = 0;
    int         n_miss    = 0;
    int         rx_frames = 0;
    bit         rx_en     = 1'b0;

    task automatic step();
        @(negedge clk);
        #1 chk_n = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb_q.push_back(e);
        chk_n++;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        bus.address    = addr;
        bus.write_data = data;
        bus.wmask      = mask;
        bus.wen        = 1'b1;
        step();
        bus.wen   = 1'b0;
        bus.wmask = 4'h0;
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.address = addr;
        expect_val(name, 0, exp);
        step();
    endtask

    task automatic chk_now(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops this cycle's expectations and compares against the selected DUT output.
    initial begin : monitor
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            for (int i = 0; i < chk_n; i++) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
                end else begin
                    e = sb_q.pop_front();
                    case (e.sel)
                        1:       act = {31'd0, uart_tx};
                        2:       act = {31'd0, timer_irq};
                        default: act = bus.read_data;
                    endcase
                    if (act !== e.exp) begin
                        n_miss++;
                        $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                    end
                end
            end
        end
    end

    // Serial receiver: samples mid-bit and checks each frame against the expected byte queue.
    initial begin : rx_monitor
        logic [7:0] b;
        logic       stop_bit;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (rx_en && uart_tx === 1'b0) begin
                repeat (CPB + 1) @(negedge clk);
                b[0] = uart_tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                stop_bit = uart_tx;
                rx_frames++;
                n_vec++;
                if (rx_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL rx_unexpected_frame: got %h, expected no frame", b);
                end else begin
                    exp_b = rx_q.pop_front();
                    if (b !== exp_b || stop_bit !== 1'b1) begin
                        n_miss++;
                        $display("FAIL rx_frame: got %h stop %b, expected %h stop 1",
                                 b, stop_bit, exp_b);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] d55;
        logic [7:0] tx_exp;
        int         t;
        d55            = 8'h55;
        bus.address    = 32'd0;
        bus.write_data = 32'd0;
        bus.wmask      = 4'h0;
        bus.wen        = 1'b0;
        @(posedge clk);
        #1;

        bus.address = A_ST;
        expect_val("rst_tx", 1, 32'd1);
        expect_val("rst_irq", 2, 32'd0);
        expect_val("rst_status", 0, 32'h0000_0002);
        step();
        rd("rst_mtime_lo", A_MLO, 32'd0);
        rd("rst_cmp_lo", A_CLO, 32'hFFFF_FFFF);
        rd("rst_cmp_hi", A_CHI, 32'hFFFF_FFFF);
        reset = 1'b0;
        step();

        wr(32'h0000_0100, 32'hAABB_CCDD, 4'hF);
        wr(32'h0000_0100, 32'h1122_3344, 4'b0010);
        rd("ram_lanes", 32'h0000_0100, 32'hAABB_33DD);
        rd("ram_alias_rd", 32'h0000_0100 + 32'd4096, 32'hAABB_33DD);
        wr(32'h0000_1100, 32'h7700_0000, 4'b1000);
        rd("ram_alias_wr", 32'h0000_0100, 32'h77BB_33DD);
        wr(32'h0000_0000, 32'h1234_5678, 4'hF);
        wr(32'h2000_0000, 32'hDEAD_BEEF, 4'hF);
        rd("unmapped_rd", 32'h2000_0000, 32'd0);
        rd("unmapped_wr_no_effect", 32'h0000_0000, 32'h1234_5678);
        rd("mmio_hole", MMIO_BASE + 32'h18, 32'd0);
        rd("txdata_rd", A_TX, 32'd0);

        rx_en = 1'b1;
        rx_q.push_back(8'h55);
        wr(A_TX, 32'h0000_0055, 4'h1);
        bus.address = A_ST;
        for (int k = 0; k <= 41; k++) begin
            if (k == 0)       tx_exp = 8'd1;
            else if (k <= 4)  tx_exp = 8'd0;
            else if (k <= 36) tx_exp = {7'd0, d55[(k - 5) / 4]};
            else              tx_exp = 8'd1;
            expect_val("frame_tx", 1, {24'd0, tx_exp});
            if (k == 0)       expect_val("frame_status", 0, 32'h0000_0100);
            else if (k <= 40) expect_val("frame_status", 0, 32'h0000_0006);
            else              expect_val("frame_status", 0, 32'h0000_0002);
            step();
        end

        for (int i = 0; i < 10; i++) begin
            if (i < 9) rx_q.push_back(8'h10 + 8'(i));
            wr(A_TX, 32'h10 + 32'(i), 4'h1);
        end
        rd("ovf_status", A_ST, 32'h0000_080D);
        t = 0;
        while (rx_q.size() != 0 && t < 1000) begin
            step();
            t++;
        end
        chk_now("rx_drain_bound", rx_q.size(), 0);
        repeat (60) step();
        chk_now("rx_frame_count", rx_frames, 10);
        rd("ovf_idle_status", A_ST, 32'h0000_000A);
        wr(A_ST, 32'h0000_0008, 4'hF);
        rd("ovf_clear", A_ST, 32'h0000_0002);

        wr(A_CHI, 32'd0, 4'hF);
        wr(A_CLO, 32'd20, 4'hF);
        wr(A_MLO, 32'd0, 4'hF);
        bus.address = A_MLO;
        step();
        for (int k = 1; k <= 21; k++) begin
            expect_val("irq_rise", 2, (k >= 21) ? 32'd1 : 32'd0);
            expect_val("mtime_count", 0, 32'(k));
            step();
        end
        wr(A_CHI, 32'd1, 4'hF);
        expect_val("irq_hold", 2, 32'd1);
        step();
        expect_val("irq_drop", 2, 32'd0);
        step();

        wr(A_MLO, 32'hFFFF_FFFE, 4'hF);
        wr(A_MHI, 32'd0, 4'hF);
        rd("carry_lo_pre", A_MLO, 32'hFFFF_FFFF);
        rd("carry_lo", A_MLO, 32'd0);
        rd("carry_hi", A_MHI, 32'd1);
        wr(A_CLO, 32'hAB00_0000, 4'b1000);
        rd("cmp_lo_masked", A_CLO, 32'hAB00_0014);

        rx_en = 1'b0;
        wr(A_TX, 32'h0000_00A5, 4'h1);
        wr(A_TX, 32'h0000_003C, 4'h1);
        repeat (16) step();
        expect_val("pre_rst_bit3", 1, 32'd0);
        step();
        reset       = 1'b1;
        bus.address = A_ST;
        expect_val("async_rst_tx", 1, 32'd1);
        expect_val("midrst_status", 0, 32'h0000_0002);
        expect_val("midrst_irq", 2, 32'd0);
        step();
        rd("midrst_mtime", A_MLO, 32'd0);
        reset = 1'b0;
        rd("post_rst_unmapped", 32'h2000_0000, 32'd0);
        rd("post_rst_ram_kept", 32'h0000_0100, 32'h77BB_33DD);
        bus.address = A_ST;
        for (int k = 0; k < 50; k++) begin
            if (k % 10 == 0) expect_val("post_rst_idle_tx", 1, 32'd1);
            step();
        end
        rd("post_rst_status", A_ST, 32'h0000_0002);
        chk_now("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
